// File: rtl/fixed_mac_seq_pkg.sv
// Shared types for the fixed-point MAC sequencer.
package fixed_mac_seq_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_seq_state_t;

endpackage

// File: rtl/fixed_mac.sv
// Unsigned fixed-point multiply-accumulate datapath, truncating modulo 2^DATA_WIDTH.
module fixed_mac #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  overwrite,
    input  logic [DATA_WIDTH-1:0] overwrite_data,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] accumulator
);

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;

    // Overwrite wins over accumulate; the product and sum both wrap at DATA_WIDTH bits.
    always_comb begin
        acc_d = acc_q;
        if (overwrite) begin
            acc_d = overwrite_data;
        end else if (in_valid) begin
            acc_d = acc_q + a * b;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign accumulator = acc_q;

endmodule

// File: rtl/fixed_mac_sequencer.sv
// Sequences one VECTOR_LEN-beat dot product through a fixed_mac datapath.
module fixed_mac_sequencer
    import fixed_mac_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned VECTOR_LEN = 8
) (
    input  logic                  core_clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned CNT_W = $clog2(VECTOR_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECTOR_LEN - 1);

    mac_seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mac_overwrite;
    logic                  beat_fire;
    logic [DATA_WIDTH-1:0] acc;

    // Handshake outputs come from registered state; clear only ever suppresses in_ready.
    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCUM) && !clear;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc;
    assign beat_fire = in_valid && in_ready;

    // Next-state, beat counter and datapath control; clear overrides everything.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mac_overwrite = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mac_overwrite = 1'b1;
                        cnt_d         = '0;
                        state_d       = ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_fire) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fixed_mac #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clk           (core_clk),
        .rst_n         (resetn),
        .overwrite     (mac_overwrite),
        .overwrite_data(bias),
        .in_valid      (beat_fire),
        .a             (a),
        .b             (b),
        .accumulator   (acc)
    );

endmodule

// File: tb/tb_fixed_mac_sequencer.sv
// Directed self-checking bench for fixed_mac_sequencer (VECTOR_LEN=4 and VECTOR_LEN=1).
module tb_fixed_mac_sequencer;

    logic        core_clk = 1'b0;
    logic        resetn;
    logic        start, clear, in_valid, out_ready;
    logic [15:0] bias, a, b;
    logic        busy, in_ready, out_valid;
    logic [15:0] out_data;

    logic        s1_start, s1_clear, s1_in_valid, s1_out_ready;
    logic [15:0] s1_bias, s1_a, s1_b;
    logic        s1_busy, s1_in_ready, s1_out_valid;
    logic [15:0] s1_out_data;

    int passed = 0;
    int total  = 0;

    always #5 core_clk = ~core_clk;

    fixed_mac_sequencer #(.DATA_WIDTH(16), .VECTOR_LEN(4)) dut (
        .core_clk(core_clk), .resetn(resetn), .start(start), .bias(bias),
        .clear(clear), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    fixed_mac_sequencer #(.DATA_WIDTH(16), .VECTOR_LEN(1)) dut1 (
        .core_clk(core_clk), .resetn(resetn), .start(s1_start), .bias(s1_bias),
        .clear(s1_clear), .busy(s1_busy), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .a(s1_a), .b(s1_b), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .out_data(s1_out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] bv);
        start = 1'b1;
        bias  = bv;
        tick();
        start = 1'b0;
    endtask

    // Present one beat (accepted at the next edge), then idle for gap cycles.
    task automatic feed(input logic [15:0] av, input logic [15:0] bv, input int gap);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_ovalid"}, out_valid, 0);
    endtask

    initial begin
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] psum [4];
        va = '{16'd1, 16'd2, 16'd3, 16'd4};
        vb = '{16'd5, 16'd6, 16'd7, 16'd8};
        psum = '{16'd15, 16'd27, 16'd48, 16'd80};

        resetn = 1'b0;
        {start, clear, in_valid, out_ready} = '0;
        bias = '0; a = '0; b = '0;
        {s1_start, s1_clear, s1_in_valid, s1_out_ready} = '0;
        s1_bias = '0; s1_a = '0; s1_b = '0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        resetn = 1'b1;
        tick();

        // Test 1: no stalls, bias 10 -> 80; out_valid only after the 4th beat edge.
        do_start(16'd10);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("t1_ovalid_early", out_valid, 0);
            feed(va[i], vb[i], 0);
        end
        check("t1_ovalid", out_valid, 1);
        check("t1_in_ready_done", in_ready, 0);
        check("t1_data", out_data, 80);
        accept("t1");

        // Test 2: two-cycle gaps between beats; accumulator holds during gaps.
        tick();
        do_start(16'd10);
        for (int i = 0; i < 4; i++) begin
            feed(va[i], vb[i], 0);
            check("t2_psum", dut.acc, psum[i]);
            if (i < 3) begin
                tick();
                tick();
                check("t2_gap_hold", dut.acc, psum[i]);
                check("t2_gap_ovalid", out_valid, 0);
            end
        end
        check("t2_ovalid", out_valid, 1);
        check("t2_data", out_data, 80);
        accept("t2");

        // Test 3: wrap-around of product and sum.
        tick();
        do_start(16'h0000);
        for (int i = 0; i < 4; i++) feed(16'h0100, 16'h0100, 0);
        check("t3a_ovalid", out_valid, 1);
        check("t3a_data", out_data, 16'h0000);
        accept("t3a");
        tick();
        do_start(16'hFFFF);
        feed(16'd1, 16'd1, 0);
        for (int i = 0; i < 3; i++) feed(16'd0, 16'd0, 0);
        check("t3b_ovalid", out_valid, 1);
        check("t3b_data", out_data, 16'h0000);
        accept("t3b");

        // Test 4: back-pressure in DONE with start pulses ignored.
        tick();
        do_start(16'd10);
        for (int i = 0; i < 4; i++) feed(va[i], vb[i], 0);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            bias  = 16'h1234;
            check("t4_hold_ovalid", out_valid, 1);
            check("t4_hold_data", out_data, 80);
            tick();
        end
        start = 1'b0;
        check("t4_after_ovalid", out_valid, 1);
        check("t4_after_data", out_data, 80);
        accept("t4");

        // Test 5: clear after two beats; the concurrent beat is refused.
        tick();
        do_start(16'd100);
        feed(16'd1, 16'd1, 0);
        feed(16'd1, 16'd1, 0);
        in_valid = 1'b1;
        a = 16'd7;
        b = 16'd7;
        clear = 1'b1;
        #1;
        check("t5_clear_in_ready", in_ready, 0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("t5_clear_busy", busy, 0);
        check("t5_acc_kept", dut.acc, 102);
        do_start(16'd1);
        for (int i = 0; i < 4; i++) feed(16'd1, 16'd1, 0);
        check("t5_ovalid", out_valid, 1);
        check("t5_data", out_data, 5);
        accept("t5");

        // Test 6: asynchronous reset mid-vector, then a fresh vector.
        tick();
        do_start(16'd50);
        feed(16'd2, 16'd2, 0);
        feed(16'd2, 16'd2, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_ovalid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        tick();
        resetn = 1'b1;
        tick();
        do_start(16'd3);
        for (int i = 0; i < 4; i++) feed(16'd2, 16'd3, 0);
        check("t6_ovalid", out_valid, 1);
        check("t6_data", out_data, 27);
        accept("t6");

        // Test 7: VECTOR_LEN=1, a single beat completes the vector.
        s1_start = 1'b1;
        s1_bias  = 16'd7;
        tick();
        s1_start = 1'b0;
        check("t7_busy", s1_busy, 1);
        check("t7_in_ready", s1_in_ready, 1);
        s1_in_valid = 1'b1;
        s1_a = 16'd3;
        s1_b = 16'd4;
        tick();
        s1_in_valid = 1'b0;
        check("t7_ovalid", s1_out_valid, 1);
        check("t7_data", s1_out_data, 19);
        s1_out_ready = 1'b1;
        tick();
        s1_out_ready = 1'b0;
        check("t7_idle", s1_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fixed_mac_sequencer.md
# fixed_mac_sequencer

Sequences one dot product of `VECTOR_LEN` element pairs through a single fixed-point multiply-accumulate datapath. It preloads the accumulator with a bias, accepts a stream of operand pairs over a valid/ready handshake, and presents the finished sum on an output valid/ready handshake. It sits between an operand-fetch stage and a downstream consumer such as an activation or writeback stage, and owns the `fixed_mac` datapath's `overwrite` and `in_valid` controls.

## Interface
- `DATA_WIDTH`, 16: width of operands, bias, accumulator and result.
- `VECTOR_LEN`, 8: number of operand pairs per dot product; must be ≥ 1.
- `core_clk`  in  1  clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a dot product; sampled only in IDLE.
- `bias`  in  DATA_WIDTH  initial accumulator value; sampled with `start`.
- `clear`  in  1  synchronous abort; returns the block to IDLE.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted when `in_valid && in_ready`.
- `a`, `b`  in  DATA_WIDTH each  operand pair.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  DATA_WIDTH  dot-product result.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE
  - `in_ready`=0 and `out_valid`=0.
  - On `start`: the accumulator loads `bias` (drives `overwrite`), the beat counter resets to 0, and the next state is ACCUM.
- ACCUM
  - `in_ready`=1.
  - Each accepted beat: accumulator += `a*b` and the counter increments.
  - When the beat accepted is number `VECTOR_LEN`-1 (counting from 0), the next state is DONE.
  - Cycles with `in_valid`=0 leave the accumulator and counter unchanged.
- DONE
  - `out_valid`=1, `in_ready`=0, and `out_data` is the accumulator value.
  - `out_valid` and `out_data` hold stable until `out_ready` is high.
  - On `out_ready`, the next state is IDLE.
- Arithmetic
  - Products and sums are unsigned and truncated modulo 2^DATA_WIDTH, with no saturation.
  - The counter is $clog2(VECTOR_LEN+1) bits wide.
- `start` is ignored outside IDLE.
- `clear` has priority over every other input in every state.
  - The next state is IDLE and the counter resets to 0.
  - The accumulator is left unchanged.
  - A beat presented in the same cycle as `clear` is not accepted: `in_ready` is forced to 0 that cycle.
- With `VECTOR_LEN`=1, a single accepted beat moves the block to DONE.

## Timing
- Reset values: state IDLE, counter 0, accumulator 0, `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0.
- Reset is honoured at any point, including mid-vector; there is no partial-result output after reset.
- `start` at edge t: `busy` and `in_ready` are high from cycle t+1.
- With no input stalls, the last beat is accepted at cycle t+`VECTOR_LEN` and `out_valid` rises at t+`VECTOR_LEN`+1.
- Result accepted at edge r: the block is in IDLE at r+1, and the earliest next `start` is at r+1. There is one mandatory idle cycle between vectors.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Package `fixed_mac_seq_pkg`: state enum `mac_seq_state_t` (IDLE, ACCUM, DONE).
- One sub-module: `fixed_mac` instantiated as the datapath.
  - `overwrite` = `start` in IDLE; `overwrite_data` = `bias`.
  - MAC `in_valid` = `in_valid && in_ready`.
  - The `accumulator` output feeds `out_data`.
- The counter and the FSM live in this module.

## Test plan
- `VECTOR_LEN`=4, bias=10, a={1,2,3,4}, b={5,6,7,8}, no stalls -> `out_data`=80, with `out_valid` exactly 5 cycles after `start`.
- Same vectors with `in_valid` low for 2 cycles between every beat -> `out_data`=80; the accumulator is unchanged during the gaps.
- bias=0, a=b=0x0100 ×4, then bias=0xFFFF with a={1,0,0,0}, b={1,0,0,0} -> results 0x0000 and 0x0000 (wrap-around).
- Hold `out_ready`=0 for 5 cycles in DONE while pulsing `start` -> `out_valid` and `out_data` stay stable, `start` is ignored, and the result is accepted on the first `out_ready`.
- `clear` after 2 beats, then `start` with bias=1 and a full vector of a=b=1 -> `busy` drops the cycle after `clear` and the next result is 5.
- Deassert `resetn` mid-ACCUM -> all outputs take their reset values immediately, and a fresh `start` produces a correct result.
